// File: rtl/pixel_cell_gen2_if.sv
// pixel_cell_gen2_if: neighbour arbitration links and readout-chain lanes
// of one pixel cell.
interface pixel_cell_gen2_if #(
    parameter int N_NEAR = 4,
    parameter int N_SUM  = 3,
    parameter int SER_W  = 2
);
    logic              discOutLocal;
    logic              discOutSumLocal;
    logic [N_NEAR-1:0] ackToNear;
    logic [N_NEAR-1:0] ackFromNear;
    logic [N_SUM-1:0]  discOutSumNear;
    logic [SER_W-1:0]  SerIn;
    logic [SER_W-1:0]  SerOut;

    modport master (
        output discOutLocal, discOutSumLocal, ackToNear, SerOut,
        input  discOutSumNear, ackFromNear, SerIn
    );

    modport slave (
        input  discOutLocal, discOutSumLocal, ackToNear, SerOut,
        output discOutSumNear, ackFromNear, SerIn
    );
endinterface

// File: rtl/pixel_cell_gen2.sv
// pixel_cell_gen2: LFSR hit counter with charge-sum arbitration and shift readout.
// PIXEL_SHUTTER_CLEAR_EN: reseed the counter on every shutter opening.
module pixel_cell_gen2 #(
    parameter int                N_NEAR    = 4,
    parameter int                N_SUM     = 3,
    parameter int                CNT_W     = 16,
    parameter int                SER_W     = 2,
    parameter logic [CNT_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter logic [N_NEAR-1:0] PRIO_MASK = 4'b0011
) (
    input  logic clock,
    input  logic reset,
    input  logic SummingMode,
    input  logic shutter,
    input  logic ReadEn,
    input  logic discIn,
    input  logic discSumIn,
    pixel_cell_gen2_if.master nb
);
    if (CNT_W % SER_W != 0) begin : gBadWidth
        $error("CNT_W must be a multiple of SER_W");
    end

    typedef enum logic [1:0] {IDLE, ARB, OWN, BLOCK} state_t;

    localparam logic [CNT_W-1:0] SEED = '1;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lfsrNext;
    logic             sync1, sync2, sync3;
    logic             sumSync1, sumSync2;
    logic             rise, riseOk, sum, beaten, nearBusy;
    logic             shift, clear, step, claim;

    assign rise     = sync2 & ~sync3;
    assign riseOk   = rise & ~clear;
    assign sum      = sumSync2 | (|nb.discOutSumNear);
    assign beaten   = |(nb.ackFromNear & PRIO_MASK);
    assign nearBusy = |nb.ackFromNear;
    assign shift    = ~shutter & ReadEn;
    assign lfsrNext = (cnt >> 1) ^ (cnt[0] ? LFSR_TAPS : '0);

`ifdef PIXEL_SHUTTER_CLEAR_EN
    logic shutterQ;

    always_ff @(posedge clock) begin
        if (!reset) shutterQ <= 1'b0;
        else        shutterQ <= shutter;
    end

    assign clear = shutter & ~shutterQ;
`else
    assign clear = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            sumSync1 <= 1'b0;
            sumSync2 <= 1'b0;
        end else begin
            sync1    <= discIn;
            sync2    <= sync1;
            sync3    <= sync2;
            sumSync1 <= discSumIn;
            sumSync2 <= sumSync1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (!shutter) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (riseOk && SummingMode)
                             stateNext = nearBusy ? BLOCK : ARB;
                ARB:     stateNext = beaten ? BLOCK : OWN;
                OWN:     if (!sync2) stateNext = IDLE;
                BLOCK:   if (!sync2 && !nearBusy) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Mode is only looked at in IDLE, so a mode flip never disturbs a claim.
    always_comb begin
        claim = 1'b0;
        step  = 1'b0;
        if (shutter) begin
            unique case (1'b1)
                state == IDLE: step = riseOk & ~SummingMode;
                state == ARB: begin
                    claim = 1'b1;
                    step  = ~beaten & sum;
                end
                state == OWN:   claim = 1'b1;
                state == BLOCK: claim = 1'b0;
                default:        claim = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)     cnt <= SEED;
        else if (shift) cnt <= {cnt[CNT_W-SER_W-1:0], nb.SerIn};
        else if (clear) cnt <= SEED;
        else if (step)  cnt <= lfsrNext;
    end

    assign nb.ackToNear       = {N_NEAR{claim}};
    assign nb.SerOut          = cnt[CNT_W-1 -: SER_W];
    assign nb.discOutLocal    = sync2;
    assign nb.discOutSumLocal = sumSync2;
endmodule

// File: doc/pixel_cell_gen2.md
# pixel_cell_gen2

Parametrised pixel counter cell for the photon-counting continuous-readout array: synchronises the local threshold and charge-sum discriminator outputs, counts hits in a Galois LFSR counter, and resolves charge-sharing events against N_NEAR neighbours with a claim/acknowledge arbiter. While the shutter is closed, the counter acts as a SER_W-lane shift stage in the column readout chain. It replaces the fixed 4-neighbour, 2-lane cell and adds configurable width, tie-break priority and explicit arbitration states.

## Interface
- N_NEAR, 4, number of arbitration neighbours (1..8)
- N_SUM, 3, number of neighbour sum-discriminator inputs (1..8)
- CNT_W, 16, counter width; must be a multiple of SER_W (elaboration error otherwise)
- SER_W, 2, serial readout lanes
- LFSR_TAPS, 16'hB400, Galois feedback mask (CNT_W bits)
- PRIO_MASK, 4'b0011, bit i set: neighbour i beats this pixel on a simultaneous claim
- clock  input  1  single cell clock
- reset  input  1  synchronous reset, active-low
- SummingMode  input  1  0 = single-pixel counting, 1 = charge-summing arbitration
- shutter  input  1  1 = acquisition open
- ReadEn  input  1  shift enable, honoured only while shutter = 0
- discIn  input  1  asynchronous local threshold discriminator
- discSumIn  input  1  asynchronous local sum discriminator
- discOutSumNear  input  N_SUM  synchronised sum discriminators from neighbours
- ackFromNear  input  N_NEAR  claim from neighbour i
- SerIn  input  SER_W  serial data from the previous pixel in the chain
- discOutLocal  output  1  synchronised discIn, to neighbours
- discOutSumLocal  output  1  synchronised discSumIn, to neighbours
- ackToNear  output  N_NEAR  this pixel's claim, same value on all bits
- SerOut  output  SER_W  counter MSBs, cnt[CNT_W-1 -: SER_W]

## Operation
- Sync: 2-flop synchroniser per discriminator; discOutLocal and discOutSumLocal are the second-stage flops. A third flop on the local path gives rise = sync2 & ~sync3.
- Counter step: lsb = cnt[0]; cnt = cnt >> 1; if lsb, cnt ^= LFSR_TAPS. Seed = all ones. The all-zero state is never reached by counting.
- Single mode (SummingMode = 0, shutter = 1): each rise steps the counter once. The FSM stays in IDLE and ackToNear = 0.
- Summing mode FSM (shutter = 1):
  - IDLE: on rise, go to ARB if ackFromNear == 0; otherwise go to BLOCK.
  - ARB, 1 cycle, ackToNear = all ones:
    - If (ackFromNear & PRIO_MASK) != 0, go to BLOCK.
    - Otherwise go to OWN, and step the counter if sum = discOutSumLocal | (|discOutSumNear) is 1 in this cycle.
  - OWN: ackToNear = all ones; return to IDLE when sync2 = 0.
  - BLOCK: ackToNear = 0, no counting; return to IDLE when sync2 = 0 and ackFromNear == 0.
- shutter = 0: FSM forced to IDLE next cycle, ackToNear = 0, no counting.
- Readout: shutter = 0 and ReadEn = 1 gives cnt <= {cnt[CNT_W-SER_W-1:0], SerIn} each cycle. A full word leaves in CNT_W/SER_W cycles.
- ReadEn while shutter = 1 is ignored. A rise while shutter = 0 is dropped.
- SummingMode changes only take effect from IDLE.
- Reset (any state, mid-shift included):
  - cnt = all ones, FSM = IDLE, synchronisers = 0.
  - Outputs: ackToNear = 0, discOutLocal = 0, discOutSumLocal = 0, SerOut = all ones.

## Timing
- discIn rising before edge E0 gives discOutLocal = 1 after E1 and the counter step (single mode) after E2.
- Summing mode: ARB is entered at E2 and the step lands at E3. ackToNear is high from E2 through OWN.
- SerOut changes one cycle after each shift edge. The first post-shift SerOut holds bits CNT_W-SER_W-1 -: SER_W.
- Shutter falling edge: counting stops at that edge; the first shift may occur on the next edge.

## Configuration
- PIXEL_SHUTTER_CLEAR_EN defined: on a shutter 0->1 edge the counter loads the seed (all ones) in that cycle. A rise in the same cycle is ignored.
- Undefined: the counter keeps its value across shutter cycles (continuous accumulate, read-out by shifting only).

## Test plan
- Reset, single mode, shutter = 1, 2 discIn pulses of 4 cycles each -> cnt = 0xCBFF then 0xD1FF; ackToNear = 0 throughout.
- Summing mode, one discIn pulse with discSumIn = 1 and ackFromNear = 0 -> ackToNear = 4'hF from E2 until 2 cycles after discIn falls; cnt = 0xCBFF.
- Summing mode, ackFromNear = 4'b0001 asserted in the ARB cycle -> BLOCK, ackToNear drops next cycle, cnt stays 0xFFFF. Repeat with 4'b0100 -> OWN, cnt = 0xCBFF.
- shutter = 0, ReadEn = 1 for 8 cycles with SerIn = 2'b10 after cnt = 0xCBFF -> SerOut sequence 3,0,2,3,3,3,3,3, then cnt = 0xAAAA.
- Reset asserted mid-shift (cycle 3 of 8) -> next cycle cnt = 0xFFFF, SerOut = 2'b11, FSM = IDLE.
- Macro on, shutter 0->1 with cnt = 0xAAAA -> cnt = 0xFFFF. Macro off -> cnt stays 0xAAAA.
